rob_commit: RTL and testbench
=============================

# rob_commit

In-order retire stage directly downstream of `reorder_buffer`. Each cycle it inspects the ROB head entry and retires it once its value is ready. Register-writing instructions go to the register file, stores are sent to data memory through a request/response handshake, and mispredicted branches trigger a pipeline flush with a PC redirect. Head pops use the ROB's `RE` strobe, and it retires at most one instruction per cycle.

## Interface
- `DATA_W`, 16, width of value/instruction/PC.
- `TAG_W`, 3, width of ROB tag / destination register field.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `empty` in 1: ROB has no entries.
- `busy_out` in 1: head value not yet produced.
- `inst_out` in DATA_W: head instruction; opcode = `[15:12]`.
- `value_out` in DATA_W: head result, store data, or branch correct target.
- `tag_out` in TAG_W: head destination register.
- `valid_out` in 1: resolved branch outcome (1 = taken).
- `predict_out` in 1: predicted branch outcome.
- `st_addr` in DATA_W: store address from load/store queue head.
- `mem_resp` in 1: memory write acknowledge.
- `RE` out 1: pop ROB head this cycle.
- `flush` out 1: clear ROB and all speculative state.
- `rf_we` out 1: register file write enable.
- `rf_dest` out TAG_W: register file destination.
- `rf_data` out DATA_W: register file write data.
- `mem_write` out 1: store request, held until `mem_resp`.
- `mem_byte` out 1: store is STB (byte).
- `mem_addr` out DATA_W: store address.
- `mem_wdata` out DATA_W: store data.
- `pc_load` out 1: load `pc_target` into fetch PC.
- `pc_target` out DATA_W: redirect address.

## Operation
- **Head readiness:** head is ready when `!empty && !busy_out`.
- **Opcode classes** (from `inst_out[15:12]`):
  - WRITE: ADD 0001, AND 0101, NOT 1001, LDB 0010, LDW 0110, LEA 1110, SHF 1101, JSR 0100.
  - STORE: STB 0011, STW 0111.
  - CTRL: BR 0000, JMP 1100.
  - NONE: all others.
- **States:** RUN, STORE, FLUSH.
- **RUN, head ready:**
  - WRITE: `rf_we=1`, `rf_dest=tag_out`, `rf_data=value_out`, `RE=1`. State stays RUN.
  - NONE: `RE=1` only.
  - CTRL, `valid_out==predict_out`: `RE=1` only.
  - CTRL, mismatch: `RE=1`, register `pc_target<=value_out`, go to FLUSH.
  - STORE: register `mem_addr<=st_addr`, `mem_wdata<=value_out`, `mem_byte<=(opcode==0011)`. Go to STORE. `RE=0`.
- **RUN, head not ready:** all strobes 0.
- **STORE:**
  - `mem_write=1` while in this state; address and data stay stable.
  - On `mem_resp`: `RE=1` in that same cycle, then go to RUN.
  - Head inputs are ignored while in STORE.
- **FLUSH:** `flush=1` and `pc_load=1` for exactly one cycle, then go to RUN. `RE=0` and `rf_we=0` in FLUSH.

## Timing
- `RE`, `rf_we`, `rf_dest` and `rf_data` are combinational from state and head inputs. The ROB and register file sample them at the next rising edge.
- **Throughput:** WRITE, NONE and correctly-predicted CTRL retire 1 per cycle back-to-back.
- **Store latency:** ≥2 cycles (entry cycle plus ≥1 STORE cycle). `mem_resp` in the first STORE cycle gives exactly 2.
- **Mispredict:** 2 cycles. The pop cycle is followed by the FLUSH cycle.
- **Reset values:**
  - State = RUN.
  - `mem_addr`, `mem_wdata`, `pc_target` = 0; `mem_byte` = 0.
  - All strobes (`RE`, `flush`, `rf_we`, `mem_write`, `pc_load`) = 0.
- **Reset mid-store:** request is abandoned; `mem_write` drops asynchronously and the entry is not popped.
- `mem_resp` outside STORE is ignored.
- `empty` with `busy_out` = X is treated as not ready.

## Configuration
- Macro: `ROB_COMMIT_PERF_EN`.
- **Defined:** adds outputs `retired_count` (16-bit) and `mispredict_count` (16-bit).
  - `retired_count` increments on every `RE` pulse.
  - `mispredict_count` increments on every entry to FLUSH.
  - Both wrap at 0xFFFF→0 and reset to 0.
- **Undefined:** ports and counters are absent; core behaviour is identical.

## Structure
- Package `rob_pkg`:
  - Opcode constants.
  - Class enum `commit_class_t` {WRITE, STORE, CTRL, NONE}.
  - State enum `commit_state_t` {RUN, STORE, FLUSH}.
  - `DATA_W` / `TAG_W` defaults.
- Sub-module `commit_decode`: combinational; maps `inst_out[15:12]` to `commit_class_t` and `mem_byte`. Reused by dispatch.

## Test plan
- Reset, then head ADD (0x1234), `tag_out=3`, `value_out=20`, ready: same cycle `rf_we=1`, `rf_dest=3`, `rf_data=20`, `RE=1`. Three ready WRITE heads give 3 pops in 3 cycles.
- `busy_out=1` head LDW for 4 cycles, then 0: no strobes for 4 cycles, then `RE`/`rf_we` on cycle 5.
- STW head, `st_addr=0x0040`, `value_out=15`, `mem_resp` 3 cycles later: `mem_write` high 3 cycles with `mem_addr=0x0040`, `mem_wdata=15`, `mem_byte=0`; `RE=1` on the `mem_resp` cycle. Repeat with STB: `mem_byte=1`.
- BR head, `predict_out=0`, `valid_out=1`, `value_out=0x0100`: `RE=1`, next cycle `flush=1`, `pc_load=1`, `pc_target=0x0100`, then idle. With matching prediction: `RE` only, no flush.
- Assert `reset` during the second STORE cycle: `mem_write`=0 immediately, `RE` never pulses, state RUN after release.
- With `ROB_COMMIT_PERF_EN`: 8 retirements including 1 mispredict → `retired_count=8`, `mispredict_count=1`.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the ROB commit stage: opcodes, retire classes, FSM states
// and default widths. Also used by dispatch through commit_decode.
package rob_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W  = 3;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDW = 4'b0110;
  localparam logic [3:0] OP_STW = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_SHF = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    CLS_WRITE,
    CLS_STORE,
    CLS_CTRL,
    CLS_NONE
  } commit_class_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_STORE,
    S_FLUSH
  } commit_state_t;

endpackage

// File: rtl/rob_commit_if.sv
// Data-memory store handshake between the commit stage (master) and memory (slave).
interface rob_commit_if
  import rob_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              mem_write;
  logic              mem_byte;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp;

  modport master (
    output mem_write, mem_byte, mem_addr, mem_wdata,
    input  mem_resp
  );

  modport slave (
    input  mem_write, mem_byte, mem_addr, mem_wdata,
    output mem_resp
  );

endinterface

// File: rtl/rob_commit_decode.sv
// Combinational opcode classifier: retire class plus byte-store flag.
module commit_decode
  import rob_pkg::*;
(
  input  logic [3:0]    opcode,
  output commit_class_t cls,
  output logic          is_byte
);

  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LDB,
      OP_LDW, OP_LEA, OP_SHF, OP_JSR: cls = CLS_WRITE;
      OP_STB, OP_STW:                 cls = CLS_STORE;
      OP_BR, OP_JMP:                  cls = CLS_CTRL;
      default:                        cls = CLS_NONE;
    endcase
  end

  assign is_byte = (opcode == OP_STB);

endmodule

// File: rtl/rob_commit.sv
// In-order retire stage behind the reorder buffer. Optional performance counters
// are compiled in when ROB_COMMIT_PERF_EN is defined.
module rob_commit
  import rob_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  input  logic              busy_out,
  input  logic [DATA_W-1:0] inst_out,
  input  logic [DATA_W-1:0] value_out,
  input  logic [TAG_W-1:0]  tag_out,
  input  logic              valid_out,
  input  logic              predict_out,
  input  logic [DATA_W-1:0] st_addr,
`ifdef ROB_COMMIT_PERF_EN
  output logic [15:0]       retired_count,
  output logic [15:0]       mispredict_count,
`endif
  rob_commit_if.master      mem,
  output logic              RE,
  output logic              flush,
  output logic              rf_we,
  output logic [TAG_W-1:0]  rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target
);

  commit_state_t     state_reg, state_next;
  commit_class_t     head_cls;
  logic              head_byte;
  logic              head_ready;
  logic              load_store, load_target;
  logic [DATA_W-1:0] mem_addr_reg, mem_wdata_reg, pc_target_reg;
  logic              mem_byte_reg;

  // Only the opcode field matters for retirement.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst_out[DATA_W-5:0];

  commit_decode u_decode (
    .opcode  (inst_out[DATA_W-1 -: 4]),
    .cls     (head_cls),
    .is_byte (head_byte)
  );

  assign head_ready = !empty && !busy_out;

  always_comb begin
    state_next  = state_reg;
    RE          = 1'b0;
    rf_we       = 1'b0;
    rf_dest     = tag_out;
    rf_data     = value_out;
    flush       = 1'b0;
    pc_load     = 1'b0;
    load_store  = 1'b0;
    load_target = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (head_ready) begin
          case (head_cls)
            CLS_WRITE: begin
              RE    = 1'b1;
              rf_we = 1'b1;
            end
            CLS_CTRL: begin
              RE = 1'b1;
              if (valid_out != predict_out) begin
                load_target = 1'b1;
                state_next  = S_FLUSH;
              end
            end
            CLS_STORE: begin
              load_store = 1'b1;
              state_next = S_STORE;
            end
            default: RE = 1'b1;
          endcase
        end
      end
      // Head inputs are frozen from our point of view until memory acknowledges.
      S_STORE: begin
        if (mem.mem_resp) begin
          RE         = 1'b1;
          state_next = S_RUN;
        end
      end
      S_FLUSH: begin
        flush      = 1'b1;
        pc_load    = 1'b1;
        state_next = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_RUN;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_byte_reg  <= 1'b0;
      pc_target_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_store) begin
        mem_addr_reg  <= st_addr;
        mem_wdata_reg <= value_out;
        mem_byte_reg  <= head_byte;
      end
      if (load_target) begin
        pc_target_reg <= value_out;
      end
    end
  end

  // Request is a pure function of state so reset withdraws it immediately.
  assign mem.mem_write = (state_reg == S_STORE);
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign mem.mem_byte  = mem_byte_reg;
  assign pc_target     = pc_target_reg;

`ifdef ROB_COMMIT_PERF_EN
  logic [15:0] retired_count_reg, mispredict_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count_reg    <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (RE) begin
        retired_count_reg <= retired_count_reg + 16'd1;
      end
      if (load_target) begin
        mispredict_count_reg <= mispredict_count_reg + 16'd1;
      end
    end
  end

  assign retired_count    = retired_count_reg;
  assign mispredict_count = mispredict_count_reg;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit: inputs driven on the falling edge,
// outputs sampled 1ns later, state updates on the rising edge.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        empty, busy_out, valid_out, predict_out;
  logic [15:0] inst_out, value_out, st_addr;
  logic [2:0]  tag_out;
  logic        RE, flush, rf_we, pc_load;
  logic [2:0]  rf_dest;
  logic [15:0] rf_data, pc_target;
`ifdef ROB_COMMIT_PERF_EN
  logic [15:0] retired_count, mispredict_count;
`endif

  int checks   = 0;
  int failures = 0;

  rob_commit_if #(.DATA_W(16)) mem_bus ();

  rob_commit dut (
    .clk              (clk),
    .reset            (reset),
    .empty            (empty),
    .busy_out         (busy_out),
    .inst_out         (inst_out),
    .value_out        (value_out),
    .tag_out          (tag_out),
    .valid_out        (valid_out),
    .predict_out      (predict_out),
    .st_addr          (st_addr),
`ifdef ROB_COMMIT_PERF_EN
    .retired_count    (retired_count),
    .mispredict_count (mispredict_count),
`endif
    .mem              (mem_bus),
    .RE               (RE),
    .flush            (flush),
    .rf_we            (rf_we),
    .rf_dest          (rf_dest),
    .rf_data          (rf_data),
    .pc_load          (pc_load),
    .pc_target        (pc_target)
  );

  always #5 clk = ~clk;

  // {RE, rf_we, mem_write, flush, pc_load}
  logic [4:0] strobes;
  assign strobes = {RE, rf_we, mem_bus.mem_write, flush, pc_load};

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic head(input logic [15:0] inst, input logic [2:0] tag,
                      input logic [15:0] val, input logic busy);
    empty     = 1'b0;
    busy_out  = busy;
    inst_out  = inst;
    tag_out   = tag;
    value_out = val;
  endtask

  task automatic idle_head();
    empty       = 1'b1;
    busy_out    = 1'bx;
    inst_out    = 16'h0000;
    valid_out   = 1'b0;
    predict_out = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_head();
    tag_out = 3'd0; value_out = 16'd0; st_addr = 16'd0;
    mem_bus.mem_resp = 1'b0;
    cycle(); #1;
    checks++;
    if (strobes !== 5'b00000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=%b", strobes, 5'b00000);
    end
    checks++;
    if ({mem_bus.mem_byte, mem_bus.mem_addr, mem_bus.mem_wdata, pc_target} !== 49'd0) begin
      failures++;
      $display("FAIL reset_regs got=%b/%h/%h/%h exp=0/0000/0000/0000",
               mem_bus.mem_byte, mem_bus.mem_addr, mem_bus.mem_wdata, pc_target);
    end
    cycle(); reset = 1'b0;
    $display("reset: strobes=%b", strobes);
  endtask

  task automatic test_write();
    int pops;
    logic [15:0] insts [3];
    insts[0] = 16'h5a01; insts[1] = 16'he123; insts[2] = 16'h4777;
    cycle();
    head(16'h1234, 3'd3, 16'd20, 1'b0); #1;
    checks++;
    if ({RE, rf_we, rf_dest, rf_data} !== {1'b1, 1'b1, 3'd3, 16'd20}) begin
      failures++;
      $display("FAIL write_add got=RE%b we%b d%0d v%0d exp=RE1 we1 d3 v20", RE, rf_we, rf_dest, rf_data);
    end
    $display("write ADD: RE=%b rf_we=%b dest=%0d data=%0d", RE, rf_we, rf_dest, rf_data);
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      head(insts[i], 3'(i + 5), 16'(100 + i), 1'b0); #1;
      if (RE && rf_we && rf_dest == 3'(i + 5) && rf_data == 16'(100 + i)) pops++;
      $display("write b2b %0d: RE=%b rf_we=%b dest=%0d data=%0d", i, RE, rf_we, rf_dest, rf_data);
    end
    checks++;
    if (pops !== 3) begin
      failures++; $display("FAIL write_back_to_back got=%0d exp=3", pops);
    end
    cycle();
    head(16'h8000, 3'd1, 16'd7, 1'b0); #1;
    checks++;
    if (strobes !== 5'b10000) begin
      failures++; $display("FAIL none_class got=%b exp=%b", strobes, 5'b10000);
    end
    $display("none class: strobes=%b", strobes);
    cycle(); idle_head(); mem_bus.mem_resp = 1'b1; #1;
    checks++;
    if (strobes !== 5'b00000) begin
      failures++; $display("FAIL empty_x_resp got=%b exp=%b", strobes, 5'b00000);
    end
    mem_bus.mem_resp = 1'b0;
  endtask

  task automatic test_busy();
    int stray;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      head(16'h6042, 3'd6, 16'h0bad, 1'b1); #1;
      if (strobes !== 5'b00000) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL busy_wait got=%0d exp=0", stray);
    end
    cycle();
    head(16'h6042, 3'd6, 16'h0abc, 1'b0); #1;
    checks++;
    if ({strobes, rf_dest, rf_data} !== {5'b11000, 3'd6, 16'h0abc}) begin
      failures++;
      $display("FAIL busy_release got=%b d%0d %h exp=11000 d6 0abc", strobes, rf_dest, rf_data);
    end
    $display("busy LDW released: strobes=%b dest=%0d data=%h", strobes, rf_dest, rf_data);
    cycle(); idle_head();
  endtask

  task automatic test_store(input logic [15:0] inst, input logic byte_exp);
    logic [32:0] req_exp;
    req_exp = {byte_exp, 16'h0040, 16'd15};
    cycle();
    head(inst, 3'd2, 16'd15, 1'b0); st_addr = 16'h0040; #1;
    checks++;
    if (strobes !== 5'b00000) begin
      failures++; $display("FAIL store_entry got=%b exp=%b", strobes, 5'b00000);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      head(16'h1fff, 3'd7, 16'hdead, 1'b0); st_addr = 16'hbeef;
      mem_bus.mem_resp = (i == 2); #1;
      checks++;
      if ({strobes, mem_bus.mem_byte, mem_bus.mem_addr, mem_bus.mem_wdata} !==
          {(i == 2), 4'b0100, req_exp}) begin
        failures++;
        $display("FAIL store_cycle%0d got=%b %b %h %h exp=%b %b 0040 000f",
                 i, strobes, mem_bus.mem_byte, mem_bus.mem_addr, mem_bus.mem_wdata,
                 {(i == 2), 4'b0100}, byte_exp);
      end
      $display("store %h cycle %0d: strobes=%b byte=%b addr=%h data=%h", inst, i,
               strobes, mem_bus.mem_byte, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    cycle(); idle_head(); mem_bus.mem_resp = 1'b0; #1;
    checks++;
    if (strobes !== 5'b00000) begin
      failures++; $display("FAIL store_done got=%b exp=%b", strobes, 5'b00000);
    end
  endtask

  task automatic test_mispredict();
    cycle();
    head(16'h0e05, 3'd0, 16'h0100, 1'b0); predict_out = 1'b0; valid_out = 1'b1; #1;
    checks++;
    if (strobes !== 5'b10000) begin
      failures++; $display("FAIL mispredict_pop got=%b exp=%b", strobes, 5'b10000);
    end
    cycle(); idle_head(); #1;
    checks++;
    if ({strobes, pc_target} !== {5'b00011, 16'h0100}) begin
      failures++; $display("FAIL mispredict_flush got=%b %h exp=00011 0100", strobes, pc_target);
    end
    $display("mispredict flush: strobes=%b pc_target=%h", strobes, pc_target);
    cycle(); #1;
    checks++;
    if (strobes !== 5'b00000) begin
      failures++; $display("FAIL mispredict_idle got=%b exp=%b", strobes, 5'b00000);
    end
    cycle();
    head(16'h0e05, 3'd0, 16'h0200, 1'b0); predict_out = 1'b1; valid_out = 1'b1; #1;
    checks++;
    if (strobes !== 5'b10000) begin
      failures++; $display("FAIL predict_ok_pop got=%b exp=%b", strobes, 5'b10000);
    end
    cycle(); idle_head(); #1;
    checks++;
    if ({strobes, pc_target} !== {5'b00000, 16'h0100}) begin
      failures++; $display("FAIL predict_ok_noflush got=%b %h exp=00000 0100", strobes, pc_target);
    end
    $display("correct prediction: strobes=%b pc_target=%h", strobes, pc_target);
  endtask

  task automatic test_reset_mid_store();
    cycle();
    head(16'h3000, 3'd1, 16'h00ab, 1'b0); st_addr = 16'h0080; #1;
    cycle(); idle_head(); #1;
    checks++;
    if (mem_bus.mem_write !== 1'b1) begin
      failures++; $display("FAIL midstore_first got=%b exp=1", mem_bus.mem_write);
    end
    cycle(); #1;
    reset = 1'b1; mem_bus.mem_resp = 1'b1; #1;
    checks++;
    if ({strobes, mem_bus.mem_addr} !== {5'b00000, 16'h0000}) begin
      failures++; $display("FAIL midstore_reset got=%b %h exp=00000 0000", strobes, mem_bus.mem_addr);
    end
    $display("reset mid-store: strobes=%b addr=%h", strobes, mem_bus.mem_addr);
    cycle(); reset = 1'b0; mem_bus.mem_resp = 1'b0;
    cycle();
    head(16'h1111, 3'd4, 16'h0044, 1'b0); #1;
    checks++;
    if (strobes !== 5'b11000) begin
      failures++; $display("FAIL midstore_run got=%b exp=%b", strobes, 5'b11000);
    end
    cycle(); idle_head();
  endtask

`ifdef ROB_COMMIT_PERF_EN
  task automatic test_perf();
    cycle(); reset = 1'b1;
    cycle(); reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle(); head(16'h1000, 3'(i), 16'(i), 1'b0);
    end
    cycle();
    head(16'hc000, 3'd0, 16'h0300, 1'b0); predict_out = 1'b1; valid_out = 1'b0;
    cycle(); idle_head();
    cycle(); #1;
    checks++;
    if ({retired_count, mispredict_count} !== {16'd8, 16'd1}) begin
      failures++;
      $display("FAIL perf_counts got=%0d/%0d exp=8/1", retired_count, mispredict_count);
    end
    $display("perf: retired=%0d mispredict=%0d", retired_count, mispredict_count);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_busy();
    test_store(16'h7000, 1'b0);
    test_store(16'h3000, 1'b1);
    test_mispredict();
    test_reset_mid_store();
`ifdef ROB_COMMIT_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
